branch_resolve_queue: RTL and testbench

Resolution-side partner to the global branch predictor. Records every IF-stage prediction in an in-order queue. When ID reports the actual branch outcome for the oldest in-flight fetch, it compares that outcome against the recorded prediction. It then generates the predictor update, the mispredict/redirect/flush controls, and performance counters.

---
 rtl/branch_resolve_queue.sv | 223 ++++++++++++++++++++++
 tb/tb_branch_resolve_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
//
// Resolution-side partner to the global branch predictor. Every prediction
// made in IF is recorded in an in-order circular queue. When ID resolves the
// oldest in-flight fetch, the recorded prediction is compared with the actual
// outcome. The block then produces the predictor update, the
// mispredict/redirect/flush controls and the performance counters.
//
// Ports
//   clk, reset         : clock; asynchronous active-low reset
//   stall              : freezes all state; pulse outputs drop to 0
//   if_valid/pc/pred   : new fetch plus its prediction (push)
//   id_valid/pc        : resolution of the oldest fetch (pop)
//   is_branch/is_taken : actual outcome of the resolved instruction
//   id_target          : taken target of the resolved branch
//   upd_valid/taken    : registered predictor update
//   mispredict         : one-cycle pulse, with redirect_pc
//   flush              : squash IF/ID, held FLUSH_CYCLES cycles
//   seq_err            : one-cycle pulse on ordering/overflow/underflow error
//   full/empty/count   : queue occupancy (registered state)
//   branch_count       : resolved conditional branches (saturating)
//   mispred_count      : mispredicted branches (saturating)
// ---------------------------------------------------------------------------
module branch_resolve_queue #(
    parameter int DEPTH        = 8,
    parameter int PTR_W        = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               if_valid,
    input  logic [31:0]        if_pc,
    input  logic               if_pred,
    input  logic               id_valid,
    input  logic [31:0]        id_pc,
    input  logic               is_branch,
    input  logic               is_taken,
    input  logic [31:0]        id_target,
    output logic               upd_valid,
    output logic               upd_taken,
    output logic               mispredict,
    output logic [31:0]        redirect_pc,
    output logic               flush,
    output logic               seq_err,
    output logic               full,
    output logic               empty,
    output logic [PTR_W:0]     count,
    output logic [CNT_W-1:0]   branch_count,
    output logic [CNT_W-1:0]   mispred_count
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    // Entry storage is data only; it is never reset.
    logic [31:0]      pc_mem   [DEPTH];
    logic [DEPTH-1:0] pred_mem;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             upd_valid_q, upd_valid_d;
    logic             upd_taken_q, upd_taken_d;
    logic             mispredict_q, mispredict_d;
    logic [31:0]      redirect_q, redirect_d;
    logic             flush_q, flush_d;
    logic             seq_err_q, seq_err_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    logic             full_w, empty_w;
    logic             pop_ok, push_ok, pc_match, wr_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign full_w  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_w = (count_q == '0);

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        fcnt_d       = fcnt_q;
        redirect_d   = redirect_q;
        flush_d      = flush_q;
        br_cnt_d     = br_cnt_q;
        mp_cnt_d     = mp_cnt_q;
        upd_valid_d  = 1'b0;
        upd_taken_d  = 1'b0;
        mispredict_d = 1'b0;
        seq_err_d    = 1'b0;
        pop_ok       = 1'b0;
        push_ok      = 1'b0;
        wr_en        = 1'b0;
        pc_match     = (pc_mem[head_q] == id_pc);

        if (!stall) begin
            case (state_q)
                S_RUN: begin
                    pop_ok  = id_valid && !empty_w;
                    // A pop in the same cycle frees the slot a full queue needs.
                    push_ok = if_valid && (!full_w || pop_ok);

                    if (if_valid && !push_ok) seq_err_d = 1'b1;
                    if (id_valid && empty_w)  seq_err_d = 1'b1;

                    if (pop_ok) begin
                        head_d = head_q + PTR_W'(1);
                        if (!pc_match) begin
                            seq_err_d = 1'b1;
                        end else begin
                            upd_valid_d = is_branch;
                            upd_taken_d = is_taken;
                            if (is_branch) br_cnt_d = sat_inc(br_cnt_q);
                            if (is_branch && (pred_mem[head_q] != is_taken)) begin
                                mispredict_d = 1'b1;
                                redirect_d   = is_taken ? id_target : id_pc + 32'd4;
                                mp_cnt_d     = sat_inc(mp_cnt_q);
                            end
                        end
                    end

                    if (push_ok) begin
                        wr_en  = 1'b1;
                        tail_d = tail_q + PTR_W'(1);
                    end

                    count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);

                    // A mispredict squashes everything younger, including
                    // any fetch being pushed this very cycle.
                    if (mispredict_d) begin
                        state_d = S_FLUSH;
                        flush_d = 1'b1;
                        fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                        head_d  = tail_q;
                        tail_d  = tail_q;
                        count_d = '0;
                        wr_en   = 1'b0;
                    end
                end

                S_FLUSH: begin
                    if (fcnt_q == '0) begin
                        state_d = S_RUN;
                        flush_d = 1'b0;
                    end else begin
                        fcnt_d = fcnt_q - FC_W'(1);
                    end
                end

                default: begin
                    state_d = S_RUN;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_RUN;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            fcnt_q       <= '0;
            upd_valid_q  <= 1'b0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            flush_q      <= 1'b0;
            seq_err_q    <= 1'b0;
            br_cnt_q     <= '0;
            mp_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            fcnt_q       <= fcnt_d;
            upd_valid_q  <= upd_valid_d;
            upd_taken_q  <= upd_taken_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            flush_q      <= flush_d;
            seq_err_q    <= seq_err_d;
            br_cnt_q     <= br_cnt_d;
            mp_cnt_q     <= mp_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[tail_q]   <= if_pc;
            pred_mem[tail_q] <= if_pred;
        end
    end

    assign upd_valid     = upd_valid_q;
    assign upd_taken     = upd_taken_q;
    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_q;
    assign flush         = flush_q;
    assign seq_err       = seq_err_q;
    assign full          = full_w;
    assign empty         = empty_w;
    assign count         = count_q;
    assign branch_count  = br_cnt_q;
    assign mispred_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_pred;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        is_branch;
    logic        is_taken;
    logic [31:0] id_target;
    logic        upd_valid, upd_taken, mispredict, flush, seq_err, full, empty;
    logic [31:0] redirect_pc;
    logic [3:0]  count;
    logic [31:0] branch_count, mispred_count;

    int tests = 0;
    int fails = 0;

    branch_resolve_queue #(.DEPTH(8), .PTR_W(3), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_pred(if_pred),
        .id_valid(id_valid), .id_pc(id_pc), .is_branch(is_branch),
        .is_taken(is_taken), .id_target(id_target),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .flush(flush), .seq_err(seq_err),
        .full(full), .empty(empty), .count(count),
        .branch_count(branch_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; if_valid = 0; if_pc = 0; if_pred = 0;
        id_valid = 0; id_pc = 0; is_branch = 0; is_taken = 0; id_target = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic pred);
        if_valid = 1; if_pc = pc; if_pred = pred;
    endtask

    task automatic pop(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
        id_valid = 1; id_pc = pc; is_branch = br; is_taken = tk; id_target = tgt;
    endtask

    task automatic test_reset();
        idle();
        reset = 0;
        #3;
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %0b exp 1", empty); end
        tests++; if ({full, flush, mispredict, seq_err, upd_valid} !== 5'b0) begin fails++; $display("FAIL reset_flags got %05b exp 00000", {full, flush, mispredict, seq_err, upd_valid}); end
        tests++; if (branch_count !== 32'd0 || mispred_count !== 32'd0) begin fails++; $display("FAIL reset_counters got %0d/%0d exp 0/0", branch_count, mispred_count); end
        #9;
        reset = 1;
        tick();
    endtask

    task automatic test_basic();
        push(32'h100, 0); tick();
        push(32'h104, 0); tick();
        push(32'h108, 0); tick();
        idle();
        tests++; if (count !== 4'd3) begin fails++; $display("FAIL basic_count got %0d exp 3", count); end
        tests++; if (empty !== 1'b0) begin fails++; $display("FAIL basic_empty got %0b exp 0", empty); end
        for (int i = 0; i < 3; i++) begin
            pop(32'h100 + 32'(4 * i), 0, 0, 0); tick();
            tests++; if (upd_valid !== 1'b0 || seq_err !== 1'b0) begin fails++; $display("FAIL basic_pop%0d got upd=%0b err=%0b exp 0 0", i, upd_valid, seq_err); end
        end
        idle();
        tests++; if (count !== 4'd0 || empty !== 1'b1) begin fails++; $display("FAIL basic_drain got count=%0d empty=%0b exp 0 1", count, empty); end
    endtask

    task automatic test_correct();
        push(32'h200, 1); tick(); idle();
        pop(32'h200, 1, 1, 32'h280); tick(); idle();
        tests++; if (upd_valid !== 1'b1 || upd_taken !== 1'b1) begin fails++; $display("FAIL correct_upd got %0b%0b exp 11", upd_valid, upd_taken); end
        tests++; if (mispredict !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL correct_nomp got mp=%0b fl=%0b exp 0 0", mispredict, flush); end
        tests++; if (branch_count !== 32'd1) begin fails++; $display("FAIL correct_brcnt got %0d exp 1", branch_count); end
        tick();
        tests++; if (upd_valid !== 1'b0) begin fails++; $display("FAIL correct_updpulse got %0b exp 0", upd_valid); end
    endtask

    task automatic test_mispredict();
        push(32'h300, 0); tick();
        push(32'h304, 0); tick(); idle();
        tests++; if (count !== 4'd2) begin fails++; $display("FAIL mp_pre_count got %0d exp 2", count); end
        pop(32'h300, 1, 1, 32'h400); tick(); idle();
        tests++; if (mispredict !== 1'b1) begin fails++; $display("FAIL mp_pulse got %0b exp 1", mispredict); end
        tests++; if (redirect_pc !== 32'h400) begin fails++; $display("FAIL mp_redirect got %0h exp 400", redirect_pc); end
        tests++; if (flush !== 1'b1 || count !== 4'd0) begin fails++; $display("FAIL mp_flush1 got fl=%0b cnt=%0d exp 1 0", flush, count); end
        tests++; if (mispred_count !== 32'd1 || branch_count !== 32'd2) begin fails++; $display("FAIL mp_counters got %0d/%0d exp 2/1", branch_count, mispred_count); end
        push(32'h308, 0); pop(32'h304, 0, 0, 0); tick();
        tests++; if (flush !== 1'b1 || mispredict !== 1'b0 || seq_err !== 1'b0 || count !== 4'd0) begin fails++; $display("FAIL mp_flush2 got fl=%0b mp=%0b err=%0b cnt=%0d exp 1 0 0 0", flush, mispredict, seq_err, count); end
        tick(); idle();
        tests++; if (flush !== 1'b0 || seq_err !== 1'b0 || count !== 4'd0) begin fails++; $display("FAIL mp_flush_end got fl=%0b err=%0b cnt=%0d exp 0 0 0", flush, seq_err, count); end
        // not-taken direction: redirect to fall-through
        push(32'h600, 1); tick(); idle();
        pop(32'h600, 1, 0, 32'h900); tick(); idle();
        tests++; if (mispredict !== 1'b1 || redirect_pc !== 32'h604) begin fails++; $display("FAIL mp_nt_redirect got mp=%0b pc=%0h exp 1 604", mispredict, redirect_pc); end
        tests++; if (upd_valid !== 1'b1 || upd_taken !== 1'b0 || mispred_count !== 32'd2) begin fails++; $display("FAIL mp_nt_upd got %0b%0b mpc=%0d exp 10 2", upd_valid, upd_taken, mispred_count); end
        tick(); tick();
        tests++; if (flush !== 1'b0) begin fails++; $display("FAIL mp_nt_flush_end got %0b exp 0", flush); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            push(32'h1000 + 32'(4 * i), 0); tick();
        end
        idle();
        tests++; if (full !== 1'b1 || count !== 4'd8) begin fails++; $display("FAIL full_fill got full=%0b cnt=%0d exp 1 8", full, count); end
        push(32'h1ff0, 0); tick(); idle();
        tests++; if (seq_err !== 1'b1 || count !== 4'd8) begin fails++; $display("FAIL full_overflow got err=%0b cnt=%0d exp 1 8", seq_err, count); end
        push(32'h2000, 0); pop(32'h1000, 0, 0, 0); tick(); idle();
        tests++; if (count !== 4'd8 || seq_err !== 1'b0 || full !== 1'b1) begin fails++; $display("FAIL full_pushpop got cnt=%0d err=%0b full=%0b exp 8 0 1", count, seq_err, full); end
        // drain: order must survive the pointer wrap
        for (int i = 1; i < 9; i++) begin
            pop((i == 8) ? 32'h2000 : 32'h1000 + 32'(4 * i), 0, 0, 0); tick();
            tests++; if (seq_err !== 1'b0) begin fails++; $display("FAIL full_drain%0d got err=%0b exp 0", i, seq_err); end
        end
        idle();
        tests++; if (count !== 4'd0 || empty !== 1'b1) begin fails++; $display("FAIL full_drained got cnt=%0d empty=%0b exp 0 1", count, empty); end
    endtask

    task automatic test_seq_err();
        pop(32'h500, 0, 0, 0); tick(); idle();
        tests++; if (seq_err !== 1'b1 || count !== 4'd0) begin fails++; $display("FAIL se_empty got err=%0b cnt=%0d exp 1 0", seq_err, count); end
        push(32'h500, 0); pop(32'h500, 1, 1, 0); tick(); idle();
        tests++; if (seq_err !== 1'b1 || count !== 4'd1 || upd_valid !== 1'b0) begin fails++; $display("FAIL se_empty_push got err=%0b cnt=%0d upd=%0b exp 1 1 0", seq_err, count, upd_valid); end
        pop(32'h504, 1, 1, 32'h700); tick(); idle();
        tests++; if (seq_err !== 1'b1 || count !== 4'd0 || upd_valid !== 1'b0 || mispredict !== 1'b0) begin fails++; $display("FAIL se_pcmismatch got err=%0b cnt=%0d upd=%0b mp=%0b exp 1 0 0 0", seq_err, count, upd_valid, mispredict); end
        tests++; if (branch_count !== 32'd3) begin fails++; $display("FAIL se_brcnt got %0d exp 3", branch_count); end
        tick();
        tests++; if (seq_err !== 1'b0) begin fails++; $display("FAIL se_pulse got %0b exp 0", seq_err); end
    endtask

    task automatic test_stall();
        stall = 1; push(32'hC00, 0); tick();
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL st_push got cnt=%0d exp 0", count); end
        stall = 0; tick(); idle();
        tests++; if (count !== 4'd1) begin fails++; $display("FAIL st_push2 got cnt=%0d exp 1", count); end
        stall = 1; pop(32'hC00, 1, 0, 0); tick();
        tests++; if (count !== 4'd1 || upd_valid !== 1'b0 || branch_count !== 32'd3) begin fails++; $display("FAIL st_pop got cnt=%0d upd=%0b br=%0d exp 1 0 3", count, upd_valid, branch_count); end
        stall = 0; tick(); idle();
        tests++; if (count !== 4'd0 || upd_valid !== 1'b1) begin fails++; $display("FAIL st_pop2 got cnt=%0d upd=%0b exp 0 1", count, upd_valid); end
        push(32'h800, 0); tick(); idle();
        pop(32'h800, 1, 1, 32'h900); tick(); idle();
        tests++; if (flush !== 1'b1 || mispredict !== 1'b1) begin fails++; $display("FAIL st_mp got fl=%0b mp=%0b exp 1 1", flush, mispredict); end
        stall = 1; push(32'h804, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (flush !== 1'b1 || count !== 4'd0 || mispredict !== 1'b0) begin fails++; $display("FAIL st_hold%0d got fl=%0b cnt=%0d mp=%0b exp 1 0 0", i, flush, count, mispredict); end
        end
        idle(); tick();
        tests++; if (flush !== 1'b1) begin fails++; $display("FAIL st_flush_last got %0b exp 1", flush); end
        tick();
        tests++; if (flush !== 1'b0) begin fails++; $display("FAIL st_flush_end got %0b exp 0", flush); end
        tests++; if (branch_count !== 32'd5 || mispred_count !== 32'd3) begin fails++; $display("FAIL st_counters got %0d/%0d exp 5/3", branch_count, mispred_count); end
    endtask

    task automatic test_reset_flush();
        push(32'hA00, 0); tick(); idle();
        pop(32'hA00, 1, 1, 32'hB00); tick(); idle();
        tests++; if (flush !== 1'b1) begin fails++; $display("FAIL rf_pre got %0b exp 1", flush); end
        #2 reset = 0;
        #1;
        tests++; if (flush !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || mispredict !== 1'b0) begin fails++; $display("FAIL rf_async got fl=%0b cnt=%0d empty=%0b mp=%0b exp 0 0 1 0", flush, count, empty, mispredict); end
        tests++; if (branch_count !== 32'd0 || mispred_count !== 32'd0) begin fails++; $display("FAIL rf_counters got %0d/%0d exp 0/0", branch_count, mispred_count); end
        #1 reset = 1;
        push(32'hB00, 0); tick(); idle();
        tests++; if (count !== 4'd1 || flush !== 1'b0) begin fails++; $display("FAIL rf_run got cnt=%0d fl=%0b exp 1 0", count, flush); end
        pop(32'hB00, 0, 0, 0); tick(); idle();
        tests++; if (count !== 4'd0 || seq_err !== 1'b0) begin fails++; $display("FAIL rf_pop got cnt=%0d err=%0b exp 0 0", count, seq_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_correct();
        test_mispredict();
        test_full();
        test_seq_err();
        test_stall();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
